uart_mem_bridge: RTL

Host-side UART command decoder that drives the debug access port of the instruction and data memories. It parses byte frames from the UART receiver into single-cycle memory read/write requests and owns the CPU run/halt enable. It captures each memory's 42-bit read response and serializes it back to the UART transmitter as bytes. It sits between the UART byte interfaces and both memories.

---
 rtl/uart_mem_bridge_pkg.sv | 31 +++
 rtl/uart_mem_bridge_tx.sv | 47 ++++
 rtl/uart_mem_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the UART memory bridge: FSM states, reply bytes,
// command byte bit positions and reply framing sizes.
package uart_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_SEND
  } state_t;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam int CMD_RW_BIT    = 7;
  localparam int CMD_MEM_BIT   = 6;
  localparam int CMD_CTRL_BIT  = 5;
  localparam int CMD_EN_BIT    = 4;
  localparam int CMD_ADDR8_BIT = 0;

  localparam int RSP_BYTES = 6;
  localparam int TX_W      = 8 * RSP_BYTES;

  // Place a single reply byte in the first-out slot of the serializer.
  function automatic logic [TX_W-1:0] single_byte(input logic [7:0] b);
    return {b, {(TX_W-8){1'b0}}};
  endfunction

endpackage

// File: rtl/uart_mem_bridge_tx.sv
// Reply serializer: loads up to six bytes at once and hands them to the UART
// transmitter MSB first, one byte per tx_valid/tx_ready handshake.
module uart_mem_bridge_tx
  import uart_mem_bridge_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [TX_W-1:0] i_data,
  input  logic [2:0]      i_count,
  input  logic            i_tx_ready,
  output logic [7:0]      o_tx_byte,
  output logic            o_tx_valid,
  output logic            o_done
);

  logic [TX_W-1:0] r_shift;
  logic [2:0]      r_left;
  logic            r_valid;
  logic            w_handshake;

  assign w_handshake = r_valid & i_tx_ready;
  assign o_tx_byte   = r_shift[TX_W-1 -: 8];
  assign o_tx_valid  = r_valid;
  assign o_done      = w_handshake & (r_left == 3'd1);

  // Load a whole reply, then shift one byte out per accepted handshake; the
  // presented byte only moves after the transmitter has taken it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_left  <= 3'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_left  <= i_count;
      r_valid <= (i_count != 3'd0);
    end else if (w_handshake) begin
      r_shift <= {r_shift[TX_W-9:0], 8'h00};
      r_left  <= r_left - 3'd1;
      if (r_left == 3'd1) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART command decoder for the instruction/data memory debug port.
// Parses command frames into single-cycle memory requests, owns the CPU
// run/halt enable and returns read responses through the reply serializer.
// Optional build macro: UART_MEM_BRIDGE_FRAME_TIMEOUT_EN discards a partial
// frame after FRAME_TIMEOUT idle cycles; without it a partial frame waits.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int RESP_TIMEOUT  = 16,
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_cpu_enable,
  output logic        o_write_mem_req,
  output logic        o_rw_flag,
  output logic        o_target_mem_type,
  output logic [8:0]  o_target_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_instr_mem_tx_data_ready,
  input  logic        i_data_mem_tx_data_ready,
  input  logic [41:0] i_instr_rsp,
  input  logic [41:0] i_data_rsp,
  output logic        o_busy
);

  localparam int RSP_CW = $clog2(RESP_TIMEOUT + 1);

  if (RESP_TIMEOUT < 1 || FRAME_TIMEOUT < 1) begin : g_param_check
    $error("uart_mem_bridge: RESP_TIMEOUT and FRAME_TIMEOUT must be at least 1");
  end

  state_t            r_state;
  logic              r_busy;
  logic              r_cpu_enable;
  logic              r_cmd_rw;
  logic              r_cmd_mem;
  logic              r_addr_hi;
  logic [7:0]        r_addr_lo;
  logic [1:0]        r_data_cnt;
  logic [31:0]       r_wdata;
  logic [RSP_CW-1:0] r_rsp_cnt;
  logic              r_write_mem_req;
  logic              r_rw_flag;
  logic              r_target_mem_type;
  logic [8:0]        r_target_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_rsp_ready;
  logic [41:0]       w_rsp;
  logic              w_rsp_ok;
  logic              w_rsp_expired;
  logic              w_frame_done;
  logic              w_frame_expired;
  logic [8:0]        w_issue_addr;
  logic [31:0]       w_wdata_next;
  logic              w_tx_load;
  logic [TX_W-1:0]   w_tx_data;
  logic [2:0]        w_tx_count;
  logic              w_tx_done;

  assign o_cpu_enable      = r_cpu_enable;
  assign o_write_mem_req   = r_write_mem_req;
  assign o_rw_flag         = r_rw_flag;
  assign o_target_mem_type = r_target_mem_type;
  assign o_target_addr     = r_target_addr;
  assign o_mem_wdata       = r_mem_wdata;
  assign o_busy            = r_busy;

  // Only the memory that was addressed may answer; the other strobe is ignored.
  assign w_rsp_ready   = r_target_mem_type ? i_instr_mem_tx_data_ready : i_data_mem_tx_data_ready;
  assign w_rsp         = r_target_mem_type ? i_instr_rsp : i_data_rsp;
  assign w_rsp_ok      = w_rsp[41] && (w_rsp[40:32] == r_target_addr);
  assign w_rsp_expired = (r_rsp_cnt == RSP_CW'(RESP_TIMEOUT - 1));

  // The last byte of a frame is the address byte of a read or the fourth data byte of a write.
  assign w_frame_done = i_rx_valid &&
                        (((r_state == ST_ADDR) && !r_cmd_rw) ||
                         ((r_state == ST_DATA) && (r_data_cnt == 2'd3)));
  assign w_issue_addr = (r_state == ST_ADDR) ? {r_addr_hi, i_rx_byte} : {r_addr_hi, r_addr_lo};
  assign w_wdata_next = {r_wdata[23:0], i_rx_byte};

`ifdef UART_MEM_BRIDGE_FRAME_TIMEOUT_EN
  localparam int FRAME_CW = $clog2(FRAME_TIMEOUT + 1);
  logic [FRAME_CW-1:0] r_frame_cnt;

  // Count idle cycles between bytes of a partially received frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
    end else if (((r_state != ST_ADDR) && (r_state != ST_DATA)) || i_rx_valid) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FRAME_CW'(1);
    end
  end

  assign w_frame_expired = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && !i_rx_valid &&
                           (r_frame_cnt == FRAME_CW'(FRAME_TIMEOUT - 1));
`else
  assign w_frame_expired = 1'b0;
`endif

  // Decide which reply, if any, gets loaded into the serializer this cycle.
  always_comb begin
    w_tx_load  = 1'b0;
    w_tx_data  = '0;
    w_tx_count = 3'd0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid && i_rx_byte[CMD_CTRL_BIT]) begin
          w_tx_load  = 1'b1;
          w_tx_data  = single_byte(ACK_BYTE);
          w_tx_count = 3'd1;
        end
      end
      ST_ISSUE: begin
        if (!r_write_mem_req) begin
          w_tx_load  = 1'b1;
          w_tx_data  = single_byte(ERR_BYTE);
          w_tx_count = 3'd1;
        end else if (r_rw_flag) begin
          w_tx_load  = 1'b1;
          w_tx_data  = single_byte(ACK_BYTE);
          w_tx_count = 3'd1;
        end
      end
      ST_WAIT_RSP: begin
        if (w_rsp_ready) begin
          w_tx_load = 1'b1;
          if (w_rsp_ok) begin
            w_tx_data  = {6'b0, w_rsp};
            w_tx_count = 3'(RSP_BYTES);
          end else begin
            w_tx_data  = single_byte(ERR_BYTE);
            w_tx_count = 3'd1;
          end
        end else if (w_rsp_expired) begin
          w_tx_load  = 1'b1;
          w_tx_data  = single_byte(ERR_BYTE);
          w_tx_count = 3'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Frame parser, request issue and reply sequencing; a request is only
  // strobed while the CPU is halted, and the request fields hold afterwards.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= ST_IDLE;
      r_busy            <= 1'b0;
      r_cpu_enable      <= 1'b1;
      r_cmd_rw          <= 1'b0;
      r_cmd_mem         <= 1'b0;
      r_addr_hi         <= 1'b0;
      r_addr_lo         <= 8'h00;
      r_data_cnt        <= 2'd0;
      r_wdata           <= 32'h0;
      r_rsp_cnt         <= '0;
      r_write_mem_req   <= 1'b0;
      r_rw_flag         <= 1'b0;
      r_target_mem_type <= 1'b0;
      r_target_addr     <= 9'h000;
      r_mem_wdata       <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            r_busy <= 1'b1;
            if (i_rx_byte[CMD_CTRL_BIT]) begin
              r_cpu_enable <= i_rx_byte[CMD_EN_BIT];
              r_state      <= ST_SEND;
            end else begin
              r_cmd_rw  <= i_rx_byte[CMD_RW_BIT];
              r_cmd_mem <= i_rx_byte[CMD_MEM_BIT];
              r_addr_hi <= i_rx_byte[CMD_ADDR8_BIT];
              r_state   <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (i_rx_valid) begin
            r_addr_lo  <= i_rx_byte;
            r_data_cnt <= 2'd0;
            r_state    <= r_cmd_rw ? ST_DATA : ST_ISSUE;
          end else if (w_frame_expired) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (i_rx_valid) begin
            r_wdata    <= w_wdata_next;
            r_data_cnt <= r_data_cnt + 2'd1;
            if (r_data_cnt == 2'd3) begin
              r_state <= ST_ISSUE;
            end
          end else if (w_frame_expired) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_write_mem_req <= 1'b0;
          r_rsp_cnt       <= '0;
          r_state         <= (r_write_mem_req && !r_rw_flag) ? ST_WAIT_RSP : ST_SEND;
        end
        ST_WAIT_RSP: begin
          if (w_tx_load) begin
            r_state <= ST_SEND;
          end else begin
            r_rsp_cnt <= r_rsp_cnt + RSP_CW'(1);
          end
        end
        ST_SEND: begin
          if (w_tx_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_frame_done && !r_cpu_enable) begin
        r_write_mem_req   <= 1'b1;
        r_rw_flag         <= r_cmd_rw;
        r_target_mem_type <= r_cmd_mem;
        r_target_addr     <= w_issue_addr;
        if (r_cmd_rw) begin
          r_mem_wdata <= w_wdata_next;
        end
      end
    end
  end

  uart_mem_bridge_tx u_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tx_load),
    .i_data     (w_tx_data),
    .i_count    (w_tx_count),
    .i_tx_ready (i_tx_ready),
    .o_tx_byte  (o_tx_byte),
    .o_tx_valid (o_tx_valid),
    .o_done     (w_tx_done)
  );

endmodule
